pa_ifu_tag_array_ctrl: RTL

PA_IFU_TAG_ARRAY_CTRL -- requirements
Module: pa_ifu_tag_array_ctrl

---
 rtl/pa_ifu_tag_array_ctrl_pkg.sv | 23 ++
 rtl/pa_ifu_tag_array_ctrl_spsram.sv | 47 ++++
 rtl/pa_ifu_tag_array_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pa_ifu_tag_array_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pa_ifu_tag_array_ctrl_pkg
// Shared IFU tag-array definitions: controller state encodings, the tag-array
// geometry and a small state-classification helper.
// ----------------------------------------------------------------------------
package pa_ifu_tag_array_ctrl_pkg;

   localparam int unsigned TAG_ENTRY_NUM = 256;
   localparam int unsigned TAG_IDX_W     = 8;
   localparam int unsigned TAG_DATA_W    = 41;

   typedef enum logic [1:0] {
      ST_RST_INV = 2'd0,
      ST_IDLE    = 2'd1,
      ST_INV     = 2'd2
   } tag_state_e;

   // True in either of the invalidate-sweep states.
   function automatic logic is_sweep(input tag_state_e st);
      return (st == ST_RST_INV) || (st == ST_INV);
   endfunction

endpackage

// File: rtl/pa_ifu_tag_array_ctrl_spsram.sv
// ----------------------------------------------------------------------------
// pa_spsram_256x41
// Pin driver for the 256x41 single-port tag SRAM. It turns one abstract access
// request (enable, write, address, data, bit mask) into the macro's
// active-low strobes. When no access is requested, every strobe is inactive.
//
// Ports
//   i_req_en     access requested this cycle
//   i_req_wr     access is a write (otherwise a read)
//   i_req_addr   entry index
//   i_req_data   write data
//   i_req_wmask  per-bit write mask, 1 = write the bit
//   o_sram_a     SRAM address
//   o_sram_cen   chip enable, active low
//   o_sram_gwen  global write enable, active low
//   o_sram_wen   per-bit write enable, active low
//   o_sram_d     SRAM write data
// ----------------------------------------------------------------------------
module pa_spsram_256x41
   import pa_ifu_tag_array_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = TAG_IDX_W,
   parameter int unsigned DATA_WIDTH = TAG_DATA_W
) (
   input  logic                  i_req_en,
   input  logic                  i_req_wr,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_data,
   input  logic [DATA_WIDTH-1:0] i_req_wmask,
   output logic [ADDR_WIDTH-1:0] o_sram_a,
   output logic                  o_sram_cen,
   output logic                  o_sram_gwen,
   output logic [DATA_WIDTH-1:0] o_sram_wen,
   output logic [DATA_WIDTH-1:0] o_sram_d
);

   logic w_wr;

   assign w_wr        = i_req_en & i_req_wr;
   assign o_sram_cen  = ~i_req_en;
   assign o_sram_gwen = ~w_wr;
   // Bit enables are only meaningful on a write; reads keep them all inactive.
   assign o_sram_wen  = w_wr ? ~i_req_wmask : '1;
   assign o_sram_a    = i_req_addr;
   assign o_sram_d    = i_req_data;

endmodule

// File: rtl/pa_ifu_tag_array_ctrl.sv
// ----------------------------------------------------------------------------
// pa_ifu_tag_array_ctrl
// IFU tag-array controller. Arbitrates refill writes (priority) and lookup
// reads onto one single-port SRAM and runs a 256-entry invalidate sweep on
// request, or automatically out of reset.
//
// Build option
//   PA_IFU_TAG_RST_INV_EN  defined: reset enters RST_INV and sweeps the array
//                          undefined: reset enters IDLE; sweeps only on inv_req
//
// Ports
//   cpuclk, cpurst        clock, synchronous active-high reset
//   inv_req / inv_done    invalidate-all request pulse / completion pulse
//   refill_vld/rdy        refill write handshake; refill_idx/data/wmask payload
//   lkup_vld/rdy          lookup read handshake; lkup_idx index
//   lkup_rslt_vld/data    read result, one cycle after an accepted lookup
//   sram_a/cen/gwen/wen/d SRAM request pins (strobes active low)
//   sram_q                SRAM read data, valid the cycle after a read
// ----------------------------------------------------------------------------
module pa_ifu_tag_array_ctrl
   import pa_ifu_tag_array_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = TAG_IDX_W,
   parameter int unsigned DATA_WIDTH = TAG_DATA_W
) (
   input  logic                  cpuclk,
   input  logic                  cpurst,
   input  logic                  inv_req,
   output logic                  inv_done,
   input  logic                  refill_vld,
   input  logic [ADDR_WIDTH-1:0] refill_idx,
   input  logic [DATA_WIDTH-1:0] refill_data,
   input  logic [DATA_WIDTH-1:0] refill_wmask,
   output logic                  refill_rdy,
   input  logic                  lkup_vld,
   input  logic [ADDR_WIDTH-1:0] lkup_idx,
   output logic                  lkup_rdy,
   output logic                  lkup_rslt_vld,
   output logic [DATA_WIDTH-1:0] lkup_rslt_data,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

`ifdef PA_IFU_TAG_RST_INV_EN
   localparam tag_state_e RST_STATE = ST_RST_INV;
`else
   localparam tag_state_e RST_STATE = ST_IDLE;
`endif

   localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(TAG_ENTRY_NUM - 1);

   tag_state_e            r_state;
   tag_state_e            w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_inv_cnt;
   logic                  r_rslt_vld;
   logic                  r_inv_done;

   logic                  w_req_en;
   logic                  w_req_wr;
   logic [ADDR_WIDTH-1:0] w_req_addr;
   logic [DATA_WIDTH-1:0] w_req_data;
   logic [DATA_WIDTH-1:0] w_req_wmask;
   logic                  w_sweep_last;

   assign w_sweep_last = is_sweep(r_state) && (r_inv_cnt == CNT_LAST);

   // State register.
   always_ff @(posedge cpuclk) begin
      if (cpurst) begin
         r_state <= RST_STATE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: inv_req only matters in IDLE, so a sweep cannot restart.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (inv_req) w_state_nxt = ST_INV;
         end
         ST_RST_INV, ST_INV: begin
            if (w_sweep_last) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs: handshakes and the SRAM request; reset and inv_req block access.
   always_comb begin
      refill_rdy  = 1'b0;
      lkup_rdy    = 1'b0;
      w_req_en    = 1'b0;
      w_req_wr    = 1'b0;
      w_req_addr  = '0;
      w_req_data  = '0;
      w_req_wmask = '0;
      if (!cpurst) begin
         case (r_state)
            ST_IDLE: begin
               if (!inv_req) begin
                  refill_rdy = refill_vld;
                  lkup_rdy   = !refill_vld;
                  if (refill_vld) begin
                     w_req_en    = 1'b1;
                     w_req_wr    = 1'b1;
                     w_req_addr  = refill_idx;
                     w_req_data  = refill_data;
                     w_req_wmask = refill_wmask;
                  end else if (lkup_vld) begin
                     w_req_en   = 1'b1;
                     w_req_addr = lkup_idx;
                  end
               end
            end
            ST_RST_INV, ST_INV: begin
               w_req_en    = 1'b1;
               w_req_wr    = 1'b1;
               w_req_addr  = r_inv_cnt;
               w_req_wmask = '1;
            end
            default: ;
         endcase
      end
   end

   // Sweep counter wraps to zero exactly as the sweep leaves; pulses are one cycle.
   always_ff @(posedge cpuclk) begin
      if (cpurst) begin
         r_inv_cnt  <= '0;
         r_rslt_vld <= 1'b0;
         r_inv_done <= 1'b0;
      end else begin
         r_rslt_vld <= lkup_vld && lkup_rdy;
         r_inv_done <= w_sweep_last;
         r_inv_cnt  <= is_sweep(r_state) ? r_inv_cnt + ADDR_WIDTH'(1) : '0;
      end
   end

   // Pulses are masked while reset is held so an aborted operation never reports.
   assign lkup_rslt_vld  = r_rslt_vld && !cpurst;
   assign inv_done       = r_inv_done && !cpurst;
   assign lkup_rslt_data = sram_q;

   pa_spsram_256x41 #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_spsram (
      .i_req_en    (w_req_en),
      .i_req_wr    (w_req_wr),
      .i_req_addr  (w_req_addr),
      .i_req_data  (w_req_data),
      .i_req_wmask (w_req_wmask),
      .o_sram_a    (sram_a),
      .o_sram_cen  (sram_cen),
      .o_sram_gwen (sram_gwen),
      .o_sram_wen  (sram_wen),
      .o_sram_d    (sram_d)
   );

endmodule
